vga_rom_renderer: RTL

- Pixel stage directly downstream of hvsync_generator in the 25 MHz video domain.
- Consumes hpos/vpos/display_on/hsync/vsync and fetches a 64x64 RGB333 image from a synchronous-read ROM, tiling it across the screen with integer scaling and optional per-frame horizontal scroll.
- Delays sync and blanking to match ROM latency and drives registered VGA pins, replacing ad-hoc colour logic in top levels.

---
 rtl/vga_rom_renderer_if.sv | 31 +++
 rtl/vga_rom_renderer.sv | 96 +++++++++
 2 files changed

// File: rtl/vga_rom_renderer_if.sv
// Bundles the timing-generator inputs, the image ROM port and the VGA pins of vga_rom_renderer.
// The renderer takes the slave view; whatever drives timing and consumes pixels takes the master view.
interface vga_rom_renderer_if #(
    parameter int IMG_BITS = 6
);
    logic [9:0]            hpos;
    logic [9:0]            vpos;
    logic                  display_on;
    logic                  hsync_in;
    logic                  vsync_in;
    logic                  enable;
    logic                  scroll_en;
    logic [2*IMG_BITS-1:0] rom_addr;
    logic [8:0]            rom_data;
    logic [2:0]            vga_red;
    logic [2:0]            vga_green;
    logic [2:0]            vga_blue;
    logic                  vga_hsync;
    logic                  vga_vsync;
    logic                  frame_done;

    modport slave (
        input  hpos, vpos, display_on, hsync_in, vsync_in, enable, scroll_en, rom_data,
        output rom_addr, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_done
    );

    modport master (
        output hpos, vpos, display_on, hsync_in, vsync_in, enable, scroll_en, rom_data,
        input  rom_addr, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_done
    );
endinterface

// File: rtl/vga_rom_renderer.sv
// Tiles a 2^IMG_BITS square RGB333 ROM image across the screen with integer scaling and per-frame
// horizontal scroll; colour, blanking and syncs all leave on the same clock, three edges after input.
module vga_rom_renderer #(
    parameter int IMG_BITS    = 6,
    parameter int SCALE       = 1,
    parameter int SCROLL_STEP = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    vga_rom_renderer_if.slave bus
);
    logic [9:0]            w_hpos_s;
    logic [9:0]            w_vpos_s;
    logic [IMG_BITS-1:0]   w_ix;
    logic [IMG_BITS-1:0]   w_iy;
    logic                  w_vs_rise;

    logic [2*IMG_BITS-1:0] r_rom_addr;
    logic [IMG_BITS-1:0]   r_xoff;
    logic                  r_vsync_prev;
    logic                  r_frame_done;
    logic                  r_de_d1, r_de_d2;
    logic                  r_en_d1, r_en_d2;
    logic                  r_hs_d1, r_hs_d2;
    logic                  r_vs_d1, r_vs_d2;
    logic [2:0]            r_red, r_green, r_blue;
    logic                  r_hsync_n, r_vsync_n;

    // Dropping the upper bits is what makes the image repeat across the screen.
    assign w_hpos_s  = bus.hpos >> SCALE;
    assign w_vpos_s  = bus.vpos >> SCALE;
    assign w_ix      = w_hpos_s[IMG_BITS-1:0] + r_xoff;
    assign w_iy      = w_vpos_s[IMG_BITS-1:0];
    assign w_vs_rise = bus.vsync_in & ~r_vsync_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rom_addr   <= '0;
            r_xoff       <= '0;
            r_vsync_prev <= 1'b0;
            r_frame_done <= 1'b0;
            r_de_d1      <= 1'b0;
            r_de_d2      <= 1'b0;
            r_en_d1      <= 1'b0;
            r_en_d2      <= 1'b0;
            r_hs_d1      <= 1'b0;
            r_hs_d2      <= 1'b0;
            r_vs_d1      <= 1'b0;
            r_vs_d2      <= 1'b0;
            r_red        <= '0;
            r_green      <= '0;
            r_blue       <= '0;
            r_hsync_n    <= 1'b1;
            r_vsync_n    <= 1'b1;
        end else begin
            r_rom_addr <= {w_iy, w_ix};

            r_de_d1 <= bus.display_on;
            r_de_d2 <= r_de_d1;
            r_en_d1 <= bus.enable;
            r_en_d2 <= r_en_d1;
            r_hs_d1 <= bus.hsync_in;
            r_hs_d2 <= r_hs_d1;
            r_vs_d1 <= bus.vsync_in;
            r_vs_d2 <= r_vs_d1;

            // rom_data lines up with the d2 flags: both are two edges behind the input sample.
            if (r_de_d2 && r_en_d2) begin
                r_red   <= bus.rom_data[8:6];
                r_green <= bus.rom_data[5:3];
                r_blue  <= bus.rom_data[2:0];
            end else begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
            end
            r_hsync_n <= ~r_hs_d2;
            r_vsync_n <= ~r_vs_d2;

            // Offset moves only at vsync rise, i.e. inside vertical blanking, so a frame never tears.
            r_vsync_prev <= bus.vsync_in;
            r_frame_done <= w_vs_rise;
            if (w_vs_rise && bus.scroll_en) begin
                r_xoff <= r_xoff + IMG_BITS'(SCROLL_STEP);
            end
        end
    end

    assign bus.rom_addr   = r_rom_addr;
    assign bus.vga_red    = r_red;
    assign bus.vga_green  = r_green;
    assign bus.vga_blue   = r_blue;
    assign bus.vga_hsync  = r_hsync_n;
    assign bus.vga_vsync  = r_vsync_n;
    assign bus.frame_done = r_frame_done;
endmodule
